// File: rtl/corelet_seq_pkg.sv
// Shared definitions for the corelet instruction sequencer: inst field
// positions, inst_w encodings, the idle word and the sequencer state type.
package corelet_pkg;

  localparam int INST_BW       = 34;
  localparam int ADDR_BW       = 11;

  localparam int ACC_B         = 33;
  localparam int PMEM_ADDR_MSB = 32;
  localparam int PMEM_ADDR_LSB = 22;
  localparam int PMEM_WEN_B    = 21;
  localparam int PMEM_CEN_B    = 20;
  localparam int XMEM_WEN_B    = 19;
  localparam int XMEM_CEN_B    = 18;
  localparam int XMEM_ADDR_MSB = 17;
  localparam int XMEM_ADDR_LSB = 7;
  localparam int OFIFO_RD_B    = 6;
  localparam int L0_RD_B       = 3;
  localparam int L0_WR_B       = 2;
  localparam int INST_W_LSB    = 0;

  localparam logic [1:0] INST_W_IDLE = 2'b00;
  localparam logic [1:0] INST_W_LOAD = 2'b01;
  localparam logic [1:0] INST_W_EXEC = 2'b10;

  // Memory enables/write-enables are active-low, so idle means all four high.
  localparam logic [INST_BW-1:0] INST_IDLE_WORD = 34'h003C0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_FETCH,
    S_W_LOAD,
    S_W_DRAIN,
    S_A_FETCH,
    S_EXEC,
    S_E_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/corelet_seq_if.sv
// Sequencer <-> corelet control bus. The master (sequencer) drives inst and
// the status outputs; the slave side drives start and the corelet flags.
interface corelet_seq_if ();

  logic                            start;
  logic                            l0_full;
  logic                            l0_ready;
  logic                            ofifo_valid;
  logic                            ofifo_full;
  logic [corelet_pkg::INST_BW-1:0] inst;
  logic                            busy;
  logic                            done;
  logic [3:0]                      kij_idx;

  modport master (
    input  start, l0_full, l0_ready, ofifo_valid, ofifo_full,
    output inst, busy, done, kij_idx
  );

  modport slave (
    output start, l0_full, l0_ready, ofifo_valid, ofifo_full,
    input  inst, busy, done, kij_idx
  );

endinterface

// File: rtl/corelet_seq_xmem_fetch_ctrl.sv
// XMEM -> L0 fetch engine shared by the weight and activation fetch phases:
// issue counter, l0_full stall, and the one-cycle-delayed l0_wr.
module xmem_fetch_ctrl
  import corelet_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic               i_l0_full,
  input  logic [ADDR_BW-1:0] i_base,
  input  logic [CNT_W-1:0]   i_count,
  output logic               o_issue,
  output logic [ADDR_BW-1:0] o_addr,
  output logic               o_l0_wr,
  output logic               o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  assign o_issue = i_en && (r_cnt < i_count) && !i_l0_full;
  assign o_addr  = i_base + ADDR_BW'(r_cnt);
  // The pending write is completed even after the phase is disabled.
  assign o_l0_wr = r_pend;
  assign o_last  = r_pend && (r_cnt == i_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= o_issue;
      if (o_last) begin
        r_cnt <= '0;
      end else if (o_issue) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/corelet_seq.sv
// Per-layer instruction sequencer for the corelet: weight fetch/load,
// activation fetch/execute and OFIFO->PMEM readout for every kernel position.
module corelet_seq
  import corelet_pkg::*;
#(
  parameter int ROW       = 8,
  parameter int COL       = 8,
  parameter int NIJ       = 36,
  parameter int KIJ       = 9,
  parameter int W_BASE    = 1024,
  parameter int A_BASE    = 0,
  parameter int DRAIN_CYC = ROW + COL,
  parameter int L0_DEPTH  = 64
) (
  input  logic          clk,
  input  logic          reset,
  corelet_seq_if.master bus
);

  localparam int FW = $clog2(L0_DEPTH) + 1;
  localparam int PW = 16;

  state_t             r_state, w_state_next;
  logic [INST_BW-1:0] r_inst, w_inst;
  logic               r_busy, r_done;
  logic [3:0]         r_kij, w_kij_next;
  logic [PW-1:0]      r_cnt, w_cnt_next;
  logic [FW-1:0]      r_rd_cnt, w_rd_cnt_next;
  logic [FW-1:0]      r_wr_cnt, w_wr_cnt_next;
  logic               r_rd_pend, w_rd_pend_next;
  logic               w_fetch_en, w_issue, w_l0_wr, w_fetch_last;
  logic [ADDR_BW-1:0] w_fetch_base, w_xmem_addr;
  logic [FW-1:0]      w_fetch_count;
  logic               w_unused;

  assign w_unused = bus.l0_ready ^ bus.ofifo_full;

  assign w_fetch_en    = (r_state == S_W_FETCH) || (r_state == S_A_FETCH);
  assign w_fetch_base  = (r_state == S_W_FETCH)
                       ? ADDR_BW'(W_BASE) + ADDR_BW'(r_kij) * ADDR_BW'(COL)
                       : ADDR_BW'(A_BASE);
  assign w_fetch_count = (r_state == S_W_FETCH) ? FW'(COL) : FW'(NIJ);

  xmem_fetch_ctrl #(
    .CNT_W (FW)
  ) u_fetch (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_fetch_en),
    .i_l0_full (bus.l0_full),
    .i_base    (w_fetch_base),
    .i_count   (w_fetch_count),
    .o_issue   (w_issue),
    .o_addr    (w_xmem_addr),
    .o_l0_wr   (w_l0_wr),
    .o_last    (w_fetch_last)
  );

  // The word computed here is registered, so it reaches the bus one cycle later.
  always_comb begin
    w_state_next   = r_state;
    w_inst         = INST_IDLE_WORD;
    w_cnt_next     = r_cnt;
    w_kij_next     = r_kij;
    w_rd_cnt_next  = r_rd_cnt;
    w_wr_cnt_next  = r_wr_cnt;
    w_rd_pend_next = 1'b0;

    if (w_issue) begin
      w_inst[XMEM_CEN_B]                   = 1'b0;
      w_inst[XMEM_ADDR_MSB:XMEM_ADDR_LSB] = w_xmem_addr;
    end
    if (w_l0_wr) begin
      w_inst[L0_WR_B] = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_kij_next    = '0;
          w_cnt_next    = '0;
          w_rd_cnt_next = '0;
          w_wr_cnt_next = '0;
          w_state_next  = S_W_FETCH;
        end
      end
      S_W_FETCH: begin
        if (w_fetch_last) begin
          w_cnt_next   = '0;
          w_state_next = S_W_LOAD;
        end
      end
      S_W_LOAD: begin
        w_inst[L0_RD_B]                  = 1'b1;
        w_inst[INST_W_LSB+1:INST_W_LSB] = INST_W_LOAD;
        if (r_cnt == PW'(COL - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_W_DRAIN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_W_DRAIN: begin
        if (r_cnt == PW'(DRAIN_CYC - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_A_FETCH;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_A_FETCH: begin
        if (w_fetch_last) begin
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_inst[L0_RD_B]                  = 1'b1;
        w_inst[INST_W_LSB+1:INST_W_LSB] = INST_W_EXEC;
        if (r_cnt == PW'(NIJ - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_E_DRAIN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_E_DRAIN: begin
        if (r_cnt == PW'(DRAIN_CYC - 1)) begin
          w_cnt_next    = '0;
          w_rd_cnt_next = '0;
          w_wr_cnt_next = '0;
          w_state_next  = S_READOUT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_READOUT: begin
        if (bus.ofifo_valid && (r_rd_cnt < FW'(NIJ))) begin
          w_inst[OFIFO_RD_B] = 1'b1;
          w_rd_pend_next     = 1'b1;
          w_rd_cnt_next      = r_rd_cnt + 1'b1;
        end
        // Row popped last cycle is on the OFIFO output now; commit it to PMEM.
        if (r_rd_pend) begin
          w_inst[PMEM_CEN_B]                   = 1'b0;
          w_inst[PMEM_WEN_B]                   = 1'b0;
          w_inst[PMEM_ADDR_MSB:PMEM_ADDR_LSB] = ADDR_BW'(r_wr_cnt);
          w_inst[ACC_B]                        = (r_kij != 4'd0);
          if (r_wr_cnt == FW'(NIJ - 1)) begin
            w_wr_cnt_next = '0;
            w_kij_next    = r_kij + 1'b1;
            w_state_next  = (r_kij == 4'(KIJ - 1)) ? S_DONE : S_W_FETCH;
          end else begin
            w_wr_cnt_next = r_wr_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_inst    <= INST_IDLE_WORD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_kij     <= '0;
      r_cnt     <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_inst    <= w_inst;
      r_busy    <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
      r_done    <= (w_state_next == S_DONE);
      r_kij     <= w_kij_next;
      r_cnt     <= w_cnt_next;
      r_rd_cnt  <= w_rd_cnt_next;
      r_wr_cnt  <= w_wr_cnt_next;
      r_rd_pend <= w_rd_pend_next;
    end
  end

  assign bus.inst    = r_inst;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.kij_idx = r_kij;

endmodule

// File: tb/tb_corelet_seq.sv
// Directed bench for corelet_seq: reset behaviour, a full default layer with
// an L0 stall and an ignored start, and a nij=1/kij=1 corner instance.
module tb_corelet_seq;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  corelet_seq_if bus ();
  corelet_seq_if bus_s ();

  corelet_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  corelet_seq #(
    .NIJ (1),
    .KIJ (1)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sm, input logic st, input logic full, input logic valid);
    if (sm) begin
      bus_s.start       = st;
      bus_s.l0_full     = full;
      bus_s.ofifo_valid = valid;
    end else begin
      bus.start         = st;
      bus.l0_full       = full;
      bus.ofifo_valid   = valid;
    end
  endtask

  // Runs one layer from a start pulse until done, checking the bus cycle by cycle.
  task automatic run_layer(input bit sm, input int nij, input int kij,
                           input bit do_stall, input bit busy_start, input string nm);
    logic [33:0] o;
    logic        bz, dn;
    logic [3:0]  kx;
    logic        issue, l0wr, l0rd, ofrd, pcen, pwen, load, exec, cur_full, cur_valid, st;
    logic [1:0]  iw;
    int c = 0, per = 8 + nij, k, r;
    longint ea;
    int n_issue = 0, n_l0wr = 0, n_pw = 0, n_ofrd = 0, n_done = 0;
    int n_load_runs = 0, n_exec_runs = 0, n_exec_cyc = 0, load_len = 0, exec_len = 0;
    int addr_err = 0, wrlag_err = 0, stall_err = 0, rd_err = 0, loadrun_err = 0;
    int execrun_err = 0, edge_err = 0, pmem_err = 0, busy_err = 0, ofrd_err = 0;
    int misc_err = 0, post_err = 0;
    int a0 = -1, first_issue = -1, busy_at1 = 0, stall_wr = 0, kij_at_done = -1;
    bit prev_issue = 0, prev_l0wr = 0, prev_ofrd = 0, prev_load = 0, prev_exec = 0;
    bit done_now = 0, timeout = 0;

    cur_full  = 1'b0;
    cur_valid = 1'b0;
    drive(sm, 1'b1, cur_full, cur_valid);
    while (1) begin
      step();
      c++;
      o  = sm ? bus_s.inst : bus.inst;
      bz = sm ? bus_s.busy : bus.busy;
      dn = sm ? bus_s.done : bus.done;
      kx = sm ? bus_s.kij_idx : bus.kij_idx;
      issue = ~o[18];
      l0wr  = o[2];
      l0rd  = o[3];
      iw    = o[1:0];
      ofrd  = o[6];
      pcen  = ~o[20];
      pwen  = ~o[21];
      load  = (iw == 2'b01);
      exec  = (iw == 2'b10);

      if (issue) begin
        k  = n_issue / per;
        r  = n_issue % per;
        ea = (r < 8) ? longint'(1024 + 8 * k + r) : longint'(r - 8);
        if (longint'(o[17:7]) != ea) addr_err++;
        if (o[19] !== 1'b1) misc_err++;
        if (cur_full) stall_err++;
        if (first_issue < 0) first_issue = c;
        if (n_issue == 8 && a0 < 0) a0 = c;
        n_issue++;
      end
      if (l0wr !== prev_issue) wrlag_err++;
      if (l0wr) n_l0wr++;
      if (do_stall && a0 >= 0 && c == a0 + 3) stall_wr = int'(l0wr);
      if ((l0rd !== (iw != 2'b00)) || iw == 2'b11) rd_err++;

      if (load && !prev_load) begin
        n_load_runs++;
        load_len = 0;
        if (!(prev_l0wr && !l0wr)) edge_err++;
      end
      if (load) load_len++;
      if (!load && prev_load && load_len != 8) loadrun_err++;
      if (exec && !prev_exec) begin
        n_exec_runs++;
        exec_len = 0;
        if (!(prev_l0wr && !l0wr)) edge_err++;
      end
      if (exec) begin
        exec_len++;
        n_exec_cyc++;
      end
      if (!exec && prev_exec && exec_len != nij) execrun_err++;

      if (ofrd) begin
        n_ofrd++;
        if (!cur_valid) ofrd_err++;
      end
      if (pcen != pwen) pmem_err++;
      if (pcen !== prev_ofrd) pmem_err++;
      if (pcen) begin
        if (longint'(o[32:22]) != longint'(n_pw % nij)) pmem_err++;
        if (o[33] !== ((n_pw / nij) != 0)) pmem_err++;
        n_pw++;
      end
      if (o[5:4] != 2'b00) misc_err++;

      if (c == 1) busy_at1 = int'(bz);
      if (dn) begin
        n_done++;
        kij_at_done = int'(kx);
        if (bz) busy_err++;
        done_now = 1;
      end else if (!bz) begin
        busy_err++;
      end

      prev_issue = issue;
      prev_l0wr  = l0wr;
      prev_ofrd  = ofrd;
      prev_load  = load;
      prev_exec  = exec;
      cur_valid  = (c % 3 != 1);
      cur_full   = do_stall && a0 >= 0 && c >= a0 + 2 && c <= a0 + 4;
      st         = busy_start && c == 100;
      drive(sm, st, cur_full, cur_valid);
      if (done_now) break;
      if (c >= 5000) begin
        timeout = 1;
        break;
      end
    end

    drive(sm, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      o  = sm ? bus_s.inst : bus.inst;
      bz = sm ? bus_s.busy : bus.busy;
      dn = sm ? bus_s.done : bus.done;
      if (bz || dn || o !== 34'h003C0000) post_err++;
    end

    chk({nm, " timeout"},        timeout, 0);
    chk({nm, " done_pulses"},    n_done, 1);
    chk({nm, " busy_after_start"}, busy_at1, 1);
    chk({nm, " first_issue_cyc"}, first_issue, 2);
    chk({nm, " xmem_issues"},    n_issue, kij * per);
    chk({nm, " l0_wr_pulses"},   n_l0wr, kij * per);
    chk({nm, " xmem_addr_err"},  addr_err, 0);
    chk({nm, " l0_wr_lag_err"},  wrlag_err, 0);
    chk({nm, " stall_issue_err"}, stall_err, 0);
    if (do_stall) chk({nm, " inflight_l0_wr"}, stall_wr, 1);
    chk({nm, " load_phases"},    n_load_runs, kij);
    chk({nm, " load_len_err"},   loadrun_err, 0);
    chk({nm, " exec_phases"},    n_exec_runs, kij);
    chk({nm, " exec_cycles"},    n_exec_cyc, kij * nij);
    chk({nm, " exec_len_err"},   execrun_err, 0);
    chk({nm, " phase_edge_err"}, edge_err, 0);
    chk({nm, " l0_rd_err"},      rd_err, 0);
    chk({nm, " pmem_writes"},    n_pw, kij * nij);
    chk({nm, " pmem_err"},       pmem_err, 0);
    chk({nm, " ofifo_reads"},    n_ofrd, kij * nij);
    chk({nm, " ofifo_rd_err"},   ofrd_err, 0);
    chk({nm, " busy_err"},       busy_err, 0);
    chk({nm, " misc_bits_err"},  misc_err, 0);
    chk({nm, " kij_at_done"},    kij_at_done, kij);
    chk({nm, " post_done_idle"}, post_err, 0);
  endtask

  initial begin
    int found;
    int rst_err;

    reset = 1'b0;
    bus.l0_ready = 1'b1;
    bus.ofifo_full = 1'b0;
    bus_s.l0_ready = 1'b1;
    bus_s.ofifo_full = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("reset inst",       longint'(bus.inst), 64'h3C0000);
    chk("reset busy",       longint'(bus.busy), 0);
    chk("reset done",       longint'(bus.done), 0);
    chk("reset kij_idx",    longint'(bus.kij_idx), 0);
    chk("reset small inst", longint'(bus_s.inst), 64'h3C0000);
    reset = 1'b1;
    repeat (2) step();
    chk("idle inst after reset", longint'(bus.inst), 64'h3C0000);

    // Reset in the middle of kernel position 3's execute phase.
    drive(0, 1'b1, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (bus.kij_idx == 4'd3 && bus.inst[1:0] == 2'b10) begin
        found = 1;
        break;
      end
    end
    chk("midrst reached kij3 exec", found, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst inst",    longint'(bus.inst), 64'h3C0000);
    chk("midrst busy",    longint'(bus.busy), 0);
    chk("midrst done",    longint'(bus.done), 0);
    chk("midrst kij_idx", longint'(bus.kij_idx), 0);
    rst_err = 0;
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      step();
      if (bus.done || bus.busy || bus.inst !== 34'h003C0000) rst_err++;
    end
    reset = 1'b1;
    repeat (5) begin
      step();
      if (bus.done || bus.busy || bus.inst !== 34'h003C0000) rst_err++;
    end
    chk("midrst stays idle", rst_err, 0);

    run_layer(0, 36, 9, 1, 1, "layer");
    run_layer(1, 1, 1, 0, 0, "small");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
